fetch_ctrl: RTL and testbench

//   Instruction-fetch sequencer in front of the ir decode block. Issues word reads at the

---
 rtl/fetch_ctrl.sv | 97 +++++++++
 tb/tb_fetch_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: reads the word at pc, latches it as ir_out, offers it via ir_valid/ir_ready.
// ir_valid rises one cycle after mem_resp; fetching stalls in HOLD while ir_ready is low.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        mem_read,
   output logic [31:0] mem_address,
   input  logic [31:0] mem_rdata,
   input  logic        mem_resp,
   output logic [31:0] ir_out,
   output logic [31:0] ir_pc,
   output logic        ir_valid,
   input  logic        ir_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] fetch_count
);

   typedef enum logic [1:0] {IDLE, FETCH, DISCARD, HOLD} state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] target;

   assign target = redirect_pc & ~32'd3;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         mem_read    <= 1'b0;
         mem_address <= 32'd0;
         ir_out      <= 32'd0;
         ir_pc       <= 32'd0;
         ir_valid    <= 1'b0;
         fetch_count <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               state    <= FETCH;
               mem_read <= 1'b1;
               if (redirect) begin
                  pc          <= target;
                  mem_address <= target;
               end else begin
                  mem_address <= pc;
               end
            end
            FETCH: begin
               if (redirect) begin
                  pc <= target;
                  // A response landing with the redirect completes the old request, so reissue at once.
                  if (mem_resp) mem_address <= target;
                  else          state       <= DISCARD;
               end else if (mem_resp) begin
                  ir_out   <= mem_rdata;
                  ir_pc    <= mem_address;
                  ir_valid <= 1'b1;
                  mem_read <= 1'b0;
                  state    <= HOLD;
               end
            end
            DISCARD: begin
               if (redirect) pc <= target;
               if (mem_resp) begin
                  state       <= FETCH;
                  mem_address <= redirect ? target : pc;
               end
            end
            HOLD: begin
               if (redirect) begin
                  pc          <= target;
                  mem_address <= target;
                  mem_read    <= 1'b1;
                  ir_valid    <= 1'b0;
                  state       <= FETCH;
                  if (ir_ready) fetch_count <= fetch_count + 32'd1;
               end else if (ir_ready) begin
                  pc          <= pc + 32'd4;
                  mem_address <= pc + 32'd4;
                  mem_read    <= 1'b1;
                  ir_valid    <= 1'b0;
                  fetch_count <= fetch_count + 32'd1;
                  state       <= FETCH;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // IDLE may still see the tail of a request abandoned by reset; only HOLD is a true protocol error.
   assert property (@(posedge clk) disable iff (!rst_n) !(mem_resp && state == HOLD));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: per-cycle vector table plus a fetch_count wrap sequence.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_read;
   logic [31:0] mem_address;
   logic [31:0] mem_rdata;
   logic        mem_resp;
   logic [31:0] ir_out;
   logic [31:0] ir_pc;
   logic        ir_valid;
   logic        ir_ready;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] fetch_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fetch_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .mem_read(mem_read), .mem_address(mem_address),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp),
      .ir_out(ir_out), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .fetch_count(fetch_count)
   );

   typedef struct {
      logic        rst;
      logic        resp;
      logic [31:0] rdata;
      logic        rdy;
      logic        redir;
      logic [31:0] rpc;
      logic        e_rd;
      logic [31:0] e_addr;
      logic [31:0] e_ir;
      logic [31:0] e_irpc;
      logic        e_vld;
      logic [31:0] e_cnt;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic rst, input logic resp, input logic [31:0] rdata,
                      input logic rdy, input logic redir, input logic [31:0] rpc,
                      input logic e_rd, input logic [31:0] e_addr, input logic [31:0] e_ir,
                      input logic [31:0] e_irpc, input logic e_vld, input logic [31:0] e_cnt);
      vec_t v;
      v.rst = rst; v.resp = resp; v.rdata = rdata; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
      v.e_rd = e_rd; v.e_addr = e_addr; v.e_ir = e_ir; v.e_irpc = e_irpc;
      v.e_vld = e_vld; v.e_cnt = e_cnt;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic resp, input logic [31:0] rdata,
                        input logic rdy, input logic redir, input logic [31:0] rpc);
      rst_n = rst; mem_resp = resp; mem_rdata = rdata;
      ir_ready = rdy; redirect = redir; redirect_pc = rpc;
   endtask

   initial begin
      drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);

      // reset, first fetch with resp on the third FETCH cycle
      add(0,0,0,0,0,0,            0,32'h0,0,0,0,0);
      add(0,0,0,0,0,0,            0,32'h0,0,0,0,0);
      add(1,0,0,0,0,0,            1,32'h60,0,0,0,0);
      add(1,0,0,0,0,0,            1,32'h60,0,0,0,0);
      add(1,0,0,0,0,0,            1,32'h60,0,0,0,0);
      add(1,1,32'h00500093,0,0,0, 0,32'h60,32'h00500093,32'h60,1,0);
      // back-to-back with ready held high
      add(1,0,0,1,0,0,            1,32'h64,32'h00500093,32'h60,0,1);
      add(1,1,32'hA1,1,0,0,       0,32'h64,32'hA1,32'h64,1,1);
      add(1,0,0,1,0,0,            1,32'h68,32'hA1,32'h64,0,2);
      add(1,1,32'hA2,1,0,0,       0,32'h68,32'hA2,32'h68,1,2);
      add(1,0,0,1,0,0,            1,32'h6C,32'hA2,32'h68,0,3);
      // redirect one cycle before resp: old address held, data dropped
      add(1,0,0,0,1,32'h1003,     1,32'h6C,32'hA2,32'h68,0,3);
      add(1,1,32'hDEAD,0,0,0,     1,32'h1000,32'hA2,32'h68,0,3);
      add(1,1,32'hB1,0,0,0,       0,32'h1000,32'hB1,32'h1000,1,3);
      // HOLD with ready low for five cycles, then redirect
      for (int i = 0; i < 5; i++)
         add(1,0,0,0,0,0,         0,32'h1000,32'hB1,32'h1000,1,3);
      add(1,0,0,0,1,32'h400,      1,32'h400,32'hB1,32'h1000,0,3);
      // redirect in the same cycle as resp
      add(1,1,32'hBAD0,0,1,32'h200, 1,32'h200,32'hB1,32'h1000,0,3);
      add(1,1,32'hC1,0,0,0,       0,32'h200,32'hC1,32'h200,1,3);
      // redirect together with ready in HOLD counts the instruction
      add(1,0,0,1,1,32'h804,      1,32'h804,32'hC1,32'h200,0,4);
      // two redirects in DISCARD: last one wins
      add(1,0,0,0,1,32'h900,      1,32'h804,32'hC1,32'h200,0,4);
      add(1,0,0,0,1,32'hA00,      1,32'h804,32'hC1,32'h200,0,4);
      add(1,1,32'hBEEF,0,0,0,     1,32'hA00,32'hC1,32'h200,0,4);
      add(1,0,0,0,0,0,            1,32'hA00,32'hC1,32'h200,0,4);
      // reset during DISCARD; stray responses ignored
      add(1,0,0,0,1,32'h123,      1,32'hA00,32'hC1,32'h200,0,4);
      add(0,0,0,0,0,0,            0,32'h0,0,0,0,0);
      add(0,1,32'hFACE,0,0,0,     0,32'h0,0,0,0,0);
      add(1,1,32'hFEED,0,0,0,     1,32'h60,0,0,0,0);
      // redirect while in IDLE loads pc
      add(0,0,0,0,0,0,            0,32'h0,0,0,0,0);
      add(1,0,0,0,1,32'h77,       1,32'h74,0,0,0,0);
      add(1,1,32'h13,0,0,0,       0,32'h74,32'h13,32'h74,1,0);

      for (int r = 0; r < tbl.size(); r++) begin
         @(negedge clk);
         drive(tbl[r].rst, tbl[r].resp, tbl[r].rdata, tbl[r].rdy, tbl[r].redir, tbl[r].rpc);
         @(posedge clk);
         #1;
         chk("mem_read",    r, {31'd0, mem_read}, {31'd0, tbl[r].e_rd});
         chk("mem_address", r, mem_address,       tbl[r].e_addr);
         chk("ir_out",      r, ir_out,            tbl[r].e_ir);
         chk("ir_pc",       r, ir_pc,             tbl[r].e_irpc);
         chk("ir_valid",    r, {31'd0, ir_valid}, {31'd0, tbl[r].e_vld});
         chk("fetch_count", r, fetch_count,       tbl[r].e_cnt);
      end

      // fetch_count wrap after a reset restart
      @(negedge clk);
      drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      @(posedge clk); #1;
      chk("wrap_rst_read", 100, {31'd0, mem_read}, 32'd0);
      @(negedge clk);
      drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      @(posedge clk); #1;
      chk("wrap_addr", 101, mem_address, 32'h60);
      @(negedge clk);
      dut.fetch_count = 32'hFFFF_FFFF;
      drive(1'b1, 1'b1, 32'h0000_0093, 1'b0, 1'b0, 32'd0);
      @(posedge clk); #1;
      chk("wrap_vld",    102, {31'd0, ir_valid}, 32'd1);
      chk("wrap_preset", 102, fetch_count, 32'hFFFF_FFFF);
      @(negedge clk);
      drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
      @(posedge clk); #1;
      chk("wrap_count", 103, fetch_count, 32'd0);
      chk("wrap_next",  103, mem_address, 32'h64);
      chk("wrap_read",  103, {31'd0, mem_read}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
